// File: rtl/regfile_arbiter.sv
// ============================================================================
// regfile_arbiter
// ----------------------------------------------------------------------------
// Round-robin arbiter and sequencer in front of a 32x64 register file that has
// one write port and one registered read port (A). The register file refreshes
// doutA only on cycles where its write enable is low, so reads and writes are
// time-multiplexed: one transaction is in flight at a time.
//
// Transaction flow (all outputs except req*_ready are registered):
//   IDLE  -> grant one requester, latch its op, present it to the RF
//   ISSUE -> write: rf_we=1 for this cycle     read: rf_ra presented, we=0
//   CAPT  -> read only: doutA is valid, capture it into the response
//   RESP  -> rsp<id>_valid held until rsp<id>_ready, then back to IDLE
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   req{0,1}_valid/ready     request handshake (ready is combinational)
//   req{0,1}_we/addr/wdata   request op, register index, write data
//   rsp{0,1}_valid/ready     response handshake
//   rsp{0,1}_rdata           read data, 0 for write acknowledges
//   rf_we/rf_rw/rf_din       register file write port
//   rf_ra/rf_dout_a          register file read port A (registered doutA)
//   busy                     a transaction is in progress
//
// Optional feature (macro REGARB_X0_PROTECT_EN):
//   defined   - writes to index 0 are acknowledged normally but rf_we stays 0,
//               so register 0 keeps its initial contents
//   undefined - index 0 is written like any other index
// ============================================================================
module regfile_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_rdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rw,
    output logic [ADDR_W-1:0] rf_ra,
    output logic [DATA_W-1:0] rf_din,
    input  logic [DATA_W-1:0] rf_dout_a,

    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPT,
        ST_RESP
    } state_t;

    state_t      r_state;
    logic        r_last_grant;   // id of the most recently granted requester
    logic        r_id;           // id of the requester owning the transaction
    logic        r_we;           // op of the transaction in flight

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_wr_en;
    logic              w_rsp_ready;

    // Round robin: on contention the requester that did not win last time
    // gets the grant. Reset leaves last_grant=1 so requester 0 wins first.
    assign w_gnt0 = req0_valid && (!req1_valid ||  r_last_grant);
    assign w_gnt1 = req1_valid && (!req0_valid || !r_last_grant);

    assign req0_ready = (r_state == ST_IDLE) && !rst && w_gnt0;
    assign req1_ready = (r_state == ST_IDLE) && !rst && w_gnt1;

    // At most one grant is active, so the granted requester's fields are
    // selected by w_gnt1 alone.
    assign w_sel_we    = w_gnt1 ? req1_we    : req0_we;
    assign w_sel_addr  = w_gnt1 ? req1_addr  : req0_addr;
    assign w_sel_wdata = w_gnt1 ? req1_wdata : req0_wdata;

`ifdef REGARB_X0_PROTECT_EN
    // Register 0 is read-only: the write is acknowledged but never strobed.
    assign w_wr_en = w_sel_we && (w_sel_addr != '0);
`else
    assign w_wr_en = w_sel_we;
`endif

    assign w_rsp_ready = r_id ? rsp1_ready : rsp0_ready;

    // Outputs are registered, so the values seen during ISSUE are loaded on
    // the grant edge, and the response is loaded on the edge leaving
    // ISSUE (write) or CAPT (read).
    // NOTE: every sequential assignment is non-blocking so all registers
    // update from the same pre-edge values; a blocking assignment here would
    // let later statements observe half-updated state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_we         <= 1'b0;
            rf_we        <= 1'b0;
            rf_rw        <= '0;
            rf_ra        <= '0;
            rf_din       <= '0;
            rsp0_valid   <= 1'b0;
            rsp0_rdata   <= '0;
            rsp1_valid   <= 1'b0;
            rsp1_rdata   <= '0;
            busy         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_id         <= w_gnt1;
                        r_last_grant <= w_gnt1;
                        r_we         <= w_sel_we;
                        busy         <= 1'b1;
                        r_state      <= ST_ISSUE;
                        if (w_sel_we) begin
                            rf_we  <= w_wr_en;
                            rf_rw  <= w_sel_addr;
                            rf_din <= w_sel_wdata;
                        end else begin
                            rf_ra  <= w_sel_addr;
                        end
                    end
                end

                ST_ISSUE: begin
                    rf_we <= 1'b0;
                    if (r_we) begin
                        // Write acknowledge carries zero data.
                        r_state <= ST_RESP;
                        if (r_id) begin
                            rsp1_valid <= 1'b1;
                            rsp1_rdata <= '0;
                        end else begin
                            rsp0_valid <= 1'b1;
                            rsp0_rdata <= '0;
                        end
                    end else begin
                        r_state <= ST_CAPT;
                    end
                end

                ST_CAPT: begin
                    // doutA was refreshed at the end of ISSUE (rf_we was low).
                    r_state <= ST_RESP;
                    if (r_id) begin
                        rsp1_valid <= 1'b1;
                        rsp1_rdata <= rf_dout_a;
                    end else begin
                        rsp0_valid <= 1'b1;
                        rsp0_rdata <= rf_dout_a;
                    end
                end

                ST_RESP: begin
                    // A stalled response intentionally blocks both requesters.
                    if (w_rsp_ready) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        busy       <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// ============================================================================
// tb_regfile_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for regfile_arbiter. A behavioural register file model
// sits on the rf_* pins. Expected grants, latencies and read data come from a
// transaction-level reference (round-robin winner variable plus an array of
// expected register contents). Directed scenarios are followed by a
// randomized run.
// ============================================================================
module tb_regfile_arbiter;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req0_ready, req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid, rsp0_ready;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              req1_valid, req1_ready, req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid, rsp1_ready;
    logic [DATA_W-1:0] rsp1_rdata;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_rw, rf_ra;
    logic [DATA_W-1:0] rf_din;
    logic [DATA_W-1:0] rf_dout_a = '0;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [DATA_W-1:0] ref_mem [32];
    int                ref_last;

    // Environment register file.
    logic [DATA_W-1:0] rf_mem [32];

    always #5 clk = ~clk;

    regfile_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_rdata (rsp0_rdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_rdata (rsp1_rdata),
        .rf_we      (rf_we),
        .rf_rw      (rf_rw),
        .rf_ra      (rf_ra),
        .rf_din     (rf_din),
        .rf_dout_a  (rf_dout_a),
        .busy       (busy)
    );

    // NOTE: the register file array has no reset; like the real macro its
    // contents survive rst, which is what makes the dropped-transaction and
    // register 0 scenarios meaningful.
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_rw] <= rf_din;
        else       rf_dout_a     <= rf_mem[rf_ra];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit x0_blocked(input logic [ADDR_W-1:0] addr);
`ifdef REGARB_X0_PROTECT_EN
        return addr == '0;
`else
        return 1'b0 && (addr == '0);
`endif
    endfunction

    // One complete transaction. Called at a negedge with the DUT idle and
    // returns at the negedge of the first idle cycle after the response.
    task automatic run_txn(input bit v0, input bit v1, input req_t q0, input req_t q1,
                           input int stall);
        int                win;
        req_t              q;
        int                lat;
        int                exp_lat;
        logic [DATA_W-1:0] exp_rdata;
        logic              got_v;
        logic [DATA_W-1:0] got_d;

        req0_valid = v0; req0_we = q0.we; req0_addr = q0.addr; req0_wdata = q0.data;
        req1_valid = v1; req1_we = q1.we; req1_addr = q1.addr; req1_wdata = q1.data;
        win = (v0 && v1) ? (ref_last == 1 ? 0 : 1) : (v0 ? 0 : 1);
        q   = (win == 0) ? q0 : q1;
        #1;
        check("req0_ready_grant", req0_ready, win == 0);
        check("req1_ready_grant", req1_ready, win == 1);

        @(negedge clk);   // ISSUE cycle
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("busy_issue", busy, 1);
        if (q.we) begin
            check("rf_we_issue", rf_we, !x0_blocked(q.addr));
            if (!x0_blocked(q.addr)) begin
                check("rf_rw_issue", rf_rw, q.addr);
                check("rf_din_issue", rf_din, q.data);
            end
        end else begin
            check("rf_we_read", rf_we, 0);
            check("rf_ra_issue", rf_ra, q.addr);
        end

        exp_lat   = q.we ? 2 : 3;
        exp_rdata = q.we ? '0 : ref_mem[q.addr];
        if (q.we && !x0_blocked(q.addr)) ref_mem[q.addr] = q.data;
        ref_last = win;

        lat = 1;
        while (!(win ? rsp1_valid : rsp0_valid) && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("rsp_latency", lat, exp_lat);
        check("rsp_rdata", win ? rsp1_rdata : rsp0_rdata, exp_rdata);
        check("rsp_other_idle", win ? rsp0_valid : rsp1_valid, 0);

        // Stall the response while the other requester asks for service.
        for (int s = 0; s < stall; s++) begin
            if (win) req0_valid = 1'b1; else req1_valid = 1'b1;
            #1;
            got_v = win ? rsp1_valid : rsp0_valid;
            got_d = win ? rsp1_rdata : rsp0_rdata;
            check("stall_valid", got_v, 1);
            check("stall_rdata", got_d, exp_rdata);
            check("stall_other_ready", win ? req0_ready : req1_ready, 0);
            check("stall_busy", busy, 1);
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (win) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_rsp_valid", rsp0_valid | rsp1_valid, 0);
    endtask

    initial begin
        req_t a, b;
        int   got [4];
        int   n_gnt;
        int   k;

        for (int i = 0; i < 32; i++) begin
            rf_mem[i]  = 64'd32 + 64'(i);
            ref_mem[i] = 64'd32 + 64'(i);
        end
        ref_last   = 1;
        rst        = 1'b1;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Reset values, and ready held low while rst is asserted.
        repeat (3) @(negedge clk);
        req0_valid = 1'b1;
        #1;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_rf_we", rf_we, 0);
        check("rst_rf_rw", rf_rw, 0);
        check("rst_rf_ra", rf_ra, 0);
        check("rst_rf_din", rf_din, 0);
        check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        check("rst_rsp0_rdata", rsp0_rdata, 0);
        check("rst_rsp1_rdata", rsp1_rdata, 0);
        check("rst_busy", busy, 0);

        // Both requesters valid from the first cycle out of reset, held
        // continuously with responses always accepted: grants alternate 0,1,0,1.
        @(negedge clk);
        rst        = 1'b0;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 5'd10; req0_wdata = 64'hAAAA_0000_0000_000A;
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 5'd11; req1_wdata = 64'hBBBB_0000_0000_000B;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        n_gnt = 0;
        for (int c = 0; c < 40 && n_gnt < 4; c++) begin
            #1;
            check("alt_onehot", req0_ready & req1_ready, 0);
            if (req0_ready)      begin got[n_gnt] = 0; n_gnt++; end
            else if (req1_ready) begin got[n_gnt] = 1; n_gnt++; end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("alt_grant_count", n_gnt, 4);
        for (int i = 0; i < n_gnt; i++) check("alt_grant_order", got[i], i % 2);
        k = 0;
        while (busy && k < 10) begin @(negedge clk); k++; end
        check("alt_drain", busy, 0);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        ref_mem[10] = 64'hAAAA_0000_0000_000A;
        ref_mem[11] = 64'hBBBB_0000_0000_000B;
        ref_last    = 1;

        // Write r5 from requester 0, read it back from requester 1.
        a = '{we: 1'b1, addr: 5'd5, data: 64'hDEADBEEF_00000001};
        b = '{we: 1'b0, addr: 5'd5, data: '0};
        run_txn(1, 0, a, b, 0);
        run_txn(0, 1, a, b, 0);

        // Read response stalled for 5 cycles while requester 1 waits.
        a = '{we: 1'b0, addr: 5'd11, data: '0};
        b = '{we: 1'b0, addr: 5'd10, data: '0};
        run_txn(1, 0, a, b, 5);

        // Register 0 write then read.
        a = '{we: 1'b0, addr: 5'd0, data: '0};
        b = '{we: 1'b1, addr: 5'd0, data: 64'h1234};
        run_txn(0, 1, a, b, 0);
        run_txn(1, 0, a, b, 0);
`ifdef REGARB_X0_PROTECT_EN
        check("x0_ref_value", ref_mem[0], 64'd32);
`else
        check("x0_ref_value", ref_mem[0], 64'h1234);
`endif

        // Reset during CAPT of a read: transaction dropped, no response.
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 5'd5;
        @(negedge clk);   // ISSUE
        req0_valid = 1'b0;
        @(negedge clk);   // CAPT
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_busy", busy, 0);
        check("rstmid_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        check("rstmid_rf_we", rf_we, 0);
        rst      = 1'b0;
        ref_last = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rstmid_no_rsp", {rsp1_valid, rsp0_valid}, 0);
            @(negedge clk);
        end

        // Randomized traffic; a narrow index range makes read-after-write hits common.
        for (int it = 0; it < 120; it++) begin
            int pat;
            pat = $urandom_range(1, 3);
            a = '{we: 1'($urandom), addr: 5'($urandom_range(0, 7)), data: {$urandom, $urandom}};
            b = '{we: 1'($urandom), addr: 5'($urandom_range(0, 7)), data: {$urandom, $urandom}};
            run_txn(pat[0], pat[1], a, b, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
